// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Time-multiplexed hex digit scanner feeding a seven-segment
//                decoder. One digit is presented per refresh slot; the
//                matching anode line is enabled and the digit's nibble and
//                decimal point are driven to the decoder. Optional
//                leading-zero blanking. New values are taken into shadow
//                registers and only become visible at slot boundaries.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock
//    rst          in   synchronous active-high reset (priority over load)
//    load_i       in   capture value/dp_mask/blank_lz into shadow registers
//    value_i      in   4*N_DIGITS hex digits, digit 0 in bits [3:0]
//    dp_mask_i    in   per-digit decimal point request
//    blank_lz_i   in   leading-zero blanking enable
//    hex_o        out  nibble for the decoder
//    dp_o         out  decimal point for the decoder, active high
//    an_o         out  one-hot digit enable, polarity set by AN_ACTIVE_LOW
//    digit_idx_o  out  index of the digit currently shown
//    slot_tick_o  out  one-cycle pulse in the first cycle of each slot
// ============================================================================
module display_scanner #(
   parameter int N_DIGITS      = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter bit AN_ACTIVE_LOW = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_i,
   input  logic [4*N_DIGITS-1:0]         value_i,
   input  logic [N_DIGITS-1:0]           dp_mask_i,
   input  logic                          blank_lz_i,
   output logic [3:0]                    hex_o,
   output logic                          dp_o,
   output logic [N_DIGITS-1:0]           an_o,
   output logic [$clog2(N_DIGITS)-1:0]   digit_idx_o,
   output logic                          slot_tick_o
);

   localparam int                  IW        = $clog2(N_DIGITS);
   localparam int                  TW        = $clog2(REFRESH_DIV);
   localparam logic [TW-1:0]       TICK_LAST = TW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
   // Anode pattern with every digit disabled; XOR-ing a one-hot vector with
   // it yields the enabled pattern in the configured polarity.
   localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [TW-1:0]         tick_q,  tick_d;
   logic [IW-1:0]         idx_q,   idx_d;
   logic [4*N_DIGITS-1:0] val_q,   val_d;
   logic [N_DIGITS-1:0]   dpm_q,   dpm_d;
   logic                  blz_q,   blz_d;
   logic [3:0]            hex_q,   hex_d;
   logic                  dp_q,    dp_d;
   logic [N_DIGITS-1:0]   an_q,    an_d;
   logic                  stick_q, stick_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                  boundary;
   logic [IW-1:0]         next_idx;
   logic [3:0]            next_nib;
   logic                  next_dp;
   logic                  next_blank;
   logic [N_DIGITS-1:0]   next_onehot;
   logic [N_DIGITS:0]     quiet;      // quiet[i]: digit i and all above are 0 with no dp
   logic [N_DIGITS-1:0]   blank_vec;

   assign boundary = (tick_q == TICK_LAST);
   assign next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

   // The shadow next-state doubles as the data the next slot is built from:
   // a load in the boundary cycle is thereby bypassed straight into the slot.
   assign val_d = load_i ? value_i    : val_q;
   assign dpm_d = load_i ? dp_mask_i  : dpm_q;
   assign blz_d = load_i ? blank_lz_i : blz_q;

   // Blanking walks down from the most significant digit; a digit is blank
   // only while everything from it upwards is zero and has no dp requested.
   assign quiet[N_DIGITS] = 1'b1;

   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_blank
      assign quiet[gi] = quiet[gi+1] & (val_d[4*gi +: 4] == 4'h0) & ~dpm_d[gi];
      if (gi == 0) begin : g_lsd
         assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
         assign blank_vec[gi] = blz_d & quiet[gi];
      end
   end

   always_comb begin
      next_nib   = 4'h0;
      next_dp    = 1'b0;
      next_blank = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (next_idx == IW'(i)) begin
            next_nib   = val_d[4*i +: 4];
            next_dp    = dpm_d[i];
            next_blank = blank_vec[i];
         end
      end
   end

   assign next_onehot = N_DIGITS'(1) << next_idx;

   // ------------------------------------------------------------------------
   // Next-state logic: outputs move only on the edge ending a boundary cycle
   // ------------------------------------------------------------------------
   always_comb begin
      tick_d  = boundary ? '0 : tick_q + TW'(1);
      idx_d   = idx_q;
      hex_d   = hex_q;
      dp_d    = dp_q;
      an_d    = an_q;
      stick_d = 1'b0;
      if (boundary) begin
         idx_d   = next_idx;
         stick_d = 1'b1;
         if (next_blank) begin
            hex_d = 4'h0;
            dp_d  = 1'b0;
            an_d  = AN_OFF;
         end else begin
            hex_d = next_nib;
            dp_d  = next_dp;
            an_d  = next_onehot ^ AN_OFF;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q  <= '0;
         idx_q   <= IDX_LAST;   // first advance lands on digit 0
         val_q   <= '0;
         dpm_q   <= '0;
         blz_q   <= 1'b0;
         hex_q   <= 4'h0;
         dp_q    <= 1'b0;
         an_q    <= AN_OFF;
         stick_q <= 1'b0;
      end else begin
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         dpm_q   <= dpm_d;
         blz_q   <= blz_d;
         hex_q   <= hex_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         stick_q <= stick_d;
      end
   end

   assign hex_o       = hex_q;
   assign dp_o        = dp_q;
   assign an_o        = an_q;
   assign digit_idx_o = idx_q;
   assign slot_tick_o = stick_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Self-checking bench for display_scanner (4 digits, 4-cycle
//                slots, active-low anodes). Stimulus queues the expected
//                contents of each upcoming slot; a monitor pops one entry per
//                slot_tick and also checks slot timing and mid-slot stability.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scanner;

   localparam int N_DIGITS    = 4;
   localparam int REFRESH_DIV = 4;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        blank_lz;
   logic [3:0]  hex;
   logic        dp;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        slot_tick;

   display_scanner #(
      .N_DIGITS      (N_DIGITS),
      .REFRESH_DIV   (REFRESH_DIV),
      .AN_ACTIVE_LOW (1'b1)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load),
      .value_i     (value),
      .dp_mask_i   (dp_mask),
      .blank_lz_i  (blank_lz),
      .hex_o       (hex),
      .dp_o        (dp),
      .an_o        (an),
      .digit_idx_o (digit_idx),
      .slot_tick_o (slot_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] idx;
      logic [3:0] hex;
      logic       dp;
      logic [3:0] an;
   } slot_t;

   slot_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    rel   = 0;     // cycle number since the last reset edge
   int    tick_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rel <= rst ? 0 : rel + 1;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   bit         prev_valid = 0;
   bit         have_tick  = 0;
   logic       prev_tick  = 1'b0;
   int         last_tick_cyc = 0;
   logic [10:0] prev_outs = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 0;
         have_tick  = 0;
         prev_tick  = 1'b0;
      end else begin
         if (slot_tick) begin
            slot_t e;
            tick_cnt++;
            check("tick_not_consecutive", int'(prev_tick), 0);
            if (have_tick) check("slot_period", cyc - last_tick_cyc, REFRESH_DIV);
            else           check("first_slot_latency", rel, REFRESH_DIV);
            if (exp_q.size() == 0) begin
               check("unexpected_slot", 0, 1);
            end else begin
               e = exp_q.pop_front();
               check("slot_idx", int'(digit_idx), int'(e.idx));
               check("slot_hex", int'(hex), int'(e.hex));
               check("slot_dp",  int'(dp),  int'(e.dp));
               check("slot_an",  int'(an),  int'(e.an));
            end
            have_tick     = 1;
            last_tick_cyc = cyc;
         end else if (prev_valid) begin
            check("midslot_hold", int'({digit_idx, hex, dp, an}), int'(prev_outs));
         end
         if (an != 4'b1111) check("an_single_low", $countones(~an), 1);
         prev_outs  = {digit_idx, hex, dp, an};
         prev_valid = 1;
         prev_tick  = slot_tick;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int k);
      int n = 0;
      while (rel != k && n < 1000) begin
         step();
         n++;
      end
      if (rel != k) check("goto_timeout", rel, k);
   endtask

   task automatic reset_with(input logic ld, input logic [15:0] v);
      rst   = 1'b1;
      load  = ld;
      value = v;
      step();
      rst   = 1'b0;
      load  = 1'b0;
   endtask

   task automatic check_reset();
      check("rst_hex",   int'(hex), 0);
      check("rst_dp",    int'(dp), 0);
      check("rst_an",    int'(an), 15);
      check("rst_idx",   int'(digit_idx), 3);
      check("rst_stick", int'(slot_tick), 0);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dpm, input logic blz);
      load     = 1'b1;
      value    = v;
      dp_mask  = dpm;
      blank_lz = blz;
      step();
      load = 1'b0;
   endtask

   task automatic push(input logic [1:0] i, input logic [3:0] h, input logic d,
                       input logic [3:0] a);
      slot_t s;
      s.idx = i; s.hex = h; s.dp = d; s.an = a;
      exp_q.push_back(s);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   initial begin
      int t0;
      rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_lz = 1'b0;
      repeat (3) step();

      // Plain scan of 1A2F, two full frames
      reset_with(1'b0, 16'h0000);
      check_reset();
      do_load(16'h1A2F, 4'b0000, 1'b0);
      for (int f = 0; f < 2; f++) begin
         push(2'd0, 4'hF, 1'b0, 4'b1110);
         push(2'd1, 4'h2, 1'b0, 4'b1101);
         push(2'd2, 4'hA, 1'b0, 4'b1011);
         push(2'd3, 4'h1, 1'b0, 4'b0111);
      end
      drain();

      // 00A3 with blanking
      reset_with(1'b0, 16'h0000);
      do_load(16'h00A3, 4'b0000, 1'b1);
      push(2'd0, 4'h3, 1'b0, 4'b1110);
      push(2'd1, 4'hA, 1'b0, 4'b1101);
      push(2'd2, 4'h0, 1'b0, 4'b1111);
      push(2'd3, 4'h0, 1'b0, 4'b1111);
      drain();

      // 00A3 without blanking
      reset_with(1'b0, 16'h0000);
      do_load(16'h00A3, 4'b0000, 1'b0);
      push(2'd0, 4'h3, 1'b0, 4'b1110);
      push(2'd1, 4'hA, 1'b0, 4'b1101);
      push(2'd2, 4'h0, 1'b0, 4'b1011);
      push(2'd3, 4'h0, 1'b0, 4'b0111);
      drain();

      // 0000 with dp on digit 2 keeps digits 0..2 lit
      reset_with(1'b0, 16'h0000);
      do_load(16'h0000, 4'b0100, 1'b1);
      push(2'd0, 4'h0, 1'b0, 4'b1110);
      push(2'd1, 4'h0, 1'b0, 4'b1101);
      push(2'd2, 4'h0, 1'b1, 4'b1011);
      push(2'd3, 4'h0, 1'b0, 4'b1111);
      drain();

      // 0000 without dp: only digit 0 lit
      reset_with(1'b0, 16'h0000);
      do_load(16'h0000, 4'b0000, 1'b1);
      push(2'd0, 4'h0, 1'b0, 4'b1110);
      push(2'd1, 4'h0, 1'b0, 4'b1111);
      push(2'd2, 4'h0, 1'b0, 4'b1111);
      push(2'd3, 4'h0, 1'b0, 4'b1111);
      drain();

      // Mid-slot load is deferred; boundary-cycle load is bypassed
      reset_with(1'b0, 16'h0000);
      do_load(16'h5678, 4'b0000, 1'b0);
      push(2'd0, 4'h8, 1'b0, 4'b1110);
      push(2'd1, 4'h7, 1'b0, 4'b1101);
      push(2'd2, 4'h2, 1'b0, 4'b1011);
      push(2'd3, 4'h9, 1'b0, 4'b0111);
      push(2'd0, 4'hC, 1'b0, 4'b1110);
      goto(9);
      do_load(16'h1234, 4'b0000, 1'b0);
      check("midslot_load_hex", int'(hex), 7);
      goto(15);
      do_load(16'h9ABC, 4'b0000, 1'b0);
      drain();

      // Reset during digit 2's slot with load high: load discarded
      reset_with(1'b0, 16'h0000);
      do_load(16'h5678, 4'b0000, 1'b0);
      push(2'd0, 4'h8, 1'b0, 4'b1110);
      push(2'd1, 4'h7, 1'b0, 4'b1101);
      push(2'd2, 4'h6, 1'b0, 4'b1011);
      goto(13);
      reset_with(1'b1, 16'hFFFF);
      check_reset();
      push(2'd0, 4'h0, 1'b0, 4'b1110);
      push(2'd1, 4'h0, 1'b0, 4'b1101);
      push(2'd2, 4'h0, 1'b0, 4'b1011);
      push(2'd3, 4'h0, 1'b0, 4'b0111);
      drain();

      // Three full frames: exactly 12 slot ticks
      reset_with(1'b0, 16'h0000);
      do_load(16'h1A2F, 4'b0000, 1'b0);
      t0 = tick_cnt;
      for (int f = 0; f < 3; f++) begin
         push(2'd0, 4'hF, 1'b0, 4'b1110);
         push(2'd1, 4'h2, 1'b0, 4'b1101);
         push(2'd2, 4'hA, 1'b0, 4'b1011);
         push(2'd3, 4'h1, 1'b0, 4'b0111);
      end
      drain();
      check("tick_count_3frames", tick_cnt - t0, 12);

      rst = 1'b1;
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
